sram_host_adapter: RTL and testbench

- Host-side front end for the single-port SRAM macro (prim_generic_ram_1p).
- Accepts byte-addressed read/write requests on a valid/ready channel and performs the range check.
- Expands byte enables into the macro's full bit mask, then drives the macro's req/write/addr/wdata/wmask.
- Returns every request (read data or write ack, plus error flag) through a credit-protected response FIFO, so host back-pressure never loses SRAM read data.

---
 rtl/sram_host_adapter_pkg.sv | 23 ++
 rtl/sram_host_adapter_rsp_fifo.sv | 56 +++++
 rtl/sram_host_adapter.sv | 128 ++++++++++++
 tb/tb_sram_host_adapter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_host_adapter_pkg.sv
// rtl/sram_host_adapter_pkg.sv - shared types and helpers for the SRAM host adapter
package sram_host_adapter_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned ByteCount    = DataWidth / 8;
  localparam int unsigned DefaultDepth = 2048;
  localparam int unsigned WordAw       = $clog2(DefaultDepth);

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } rsp_entry_t;

  function automatic logic [DataWidth-1:0] be_to_bitmask(input logic [ByteCount-1:0] be);
    logic [DataWidth-1:0] mask;
    mask = '0;
    for (int i = 0; i < ByteCount; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/sram_host_adapter_rsp_fifo.sv
// rtl/sram_host_adapter_rsp_fifo.sv - synchronous FIFO holding host responses
module sram_host_adapter_rsp_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned DataW = 33,
  localparam int unsigned CntW = $clog2(Depth + 1),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [DataW-1:0] wdata,
  output logic [DataW-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [DataW-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so Depth need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CntW'(Depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop) begin
        count <= count + CntW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sram_host_adapter.sv
// rtl/sram_host_adapter.sv - host front end for prim_generic_ram_1p; option SRAM_HOST_ADAPTER_RSP_BYPASS_EN
module sram_host_adapter
  import sram_host_adapter_pkg::*;
#(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 2048,
  parameter int unsigned HostAw   = 32,
  parameter int unsigned RspDepth = 2,
  localparam int unsigned Aw      = $clog2(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [HostAw-1:0]   req_addr_i,
  input  logic [Width-1:0]    req_wdata_i,
  input  logic [Width/8-1:0]  req_be_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [Width-1:0]    rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                ram_req_o,
  output logic                ram_write_o,
  output logic [Aw-1:0]       ram_addr_o,
  output logic [Width-1:0]    ram_wdata_o,
  output logic [Width-1:0]    ram_wmask_o,
  input  logic                ram_rvalid_i,
  input  logic [Width-1:0]    ram_rdata_i
);

  localparam int unsigned CntW = $clog2(RspDepth + 1);
  localparam int unsigned OutW = CntW + 1;

  logic            addr_err;
  logic            accept;
  logic            inflight_vld;
  logic            inflight_we;
  logic            inflight_err;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic            bypass;
  logic            credit_free;
  logic [CntW-1:0] fifo_count;
  logic [OutW-1:0] outstanding;
  rsp_entry_t      new_entry;
  rsp_entry_t      fifo_head;
  rsp_entry_t      rsp_entry;
  logic [1:0]      unused_addr_lsb;

  assign unused_addr_lsb = req_addr_i[1:0];
  assign addr_err        = |req_addr_i[HostAw-1:Aw+2];

  // A response leaving this cycle frees its credit immediately, keeping one request per cycle.
  assign outstanding = OutW'(fifo_count) + OutW'(inflight_vld) - OutW'(credit_free);
  assign req_ready_o = !rst_i && (outstanding < OutW'(RspDepth));
  assign accept      = req_valid_i && req_ready_o;

  assign ram_req_o   = accept && !addr_err;
  assign ram_write_o = ram_req_o && req_we_i;
  assign ram_addr_o  = ram_req_o ? req_addr_i[Aw+1:2] : '0;
  assign ram_wdata_o = ram_req_o ? req_wdata_i : '0;
  assign ram_wmask_o = ram_req_o ? Width'(be_to_bitmask(ByteCount'(req_be_i))) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_vld <= 1'b0;
      inflight_we  <= 1'b0;
      inflight_err <= 1'b0;
    end else begin
      inflight_vld <= accept;
      if (accept) begin
        inflight_we  <= req_we_i;
        inflight_err <= addr_err;
      end
    end
  end

  always_comb begin
    new_entry     = '0;
    new_entry.err = inflight_err;
    if (!inflight_we && !inflight_err && ram_rvalid_i) begin
      new_entry.rdata = DataWidth'(ram_rdata_i);
    end
  end

`ifdef SRAM_HOST_ADAPTER_RSP_BYPASS_EN
  assign bypass      = !rst_i && inflight_vld && fifo_empty && rsp_ready_i;
  assign rsp_entry   = fifo_empty ? new_entry : fifo_head;
  assign rsp_valid_o = !rst_i && (!fifo_empty || bypass);
`else
  assign bypass      = 1'b0;
  assign rsp_entry   = fifo_head;
  assign rsp_valid_o = !rst_i && !fifo_empty;
`endif

  assign fifo_push   = inflight_vld && !bypass;
  assign fifo_pop    = rsp_valid_o && rsp_ready_i && !fifo_empty;
  assign credit_free = fifo_pop || bypass;

  assign rsp_rdata_o = rsp_valid_o ? Width'(rsp_entry.rdata) : '0;
  assign rsp_err_o   = rsp_valid_o && rsp_entry.err;

  sram_host_adapter_rsp_fifo #(
    .Depth (RspDepth),
    .DataW ($bits(rsp_entry_t))
  ) u_rsp_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (new_entry),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The macro must answer every issued read on the following cycle.
  read_rvalid_a : assert property (@(posedge clk_i) disable iff (rst_i)
    (inflight_vld && !inflight_we && !inflight_err) |-> ram_rvalid_i);

  no_overflow_a : assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_push |-> (!fifo_full || fifo_pop));

endmodule

// File: tb/tb_sram_host_adapter.sv
// tb/tb_sram_host_adapter.sv - directed self-checking bench for sram_host_adapter
module tb_sram_host_adapter;

  localparam int unsigned Width    = 32;
  localparam int unsigned Depth    = 2048;
  localparam int unsigned HostAw   = 32;
  localparam int unsigned RspDepth = 2;
  localparam int unsigned Aw       = 11;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [HostAw-1:0] req_addr_i;
  logic [Width-1:0]  req_wdata_i;
  logic [3:0]        req_be_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [Width-1:0]  rsp_rdata_o;
  logic              rsp_err_o;
  logic              ram_req_o;
  logic              ram_write_o;
  logic [Aw-1:0]     ram_addr_o;
  logic [Width-1:0]  ram_wdata_o;
  logic [Width-1:0]  ram_wmask_o;
  logic              ram_rvalid_i = 1'b0;
  logic [Width-1:0]  ram_rdata_i  = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  sram_host_adapter #(
    .Width    (Width),
    .Depth    (Depth),
    .HostAw   (HostAw),
    .RspDepth (RspDepth)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_be_i     (req_be_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .ram_req_o    (ram_req_o),
    .ram_write_o  (ram_write_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_wmask_o  (ram_wmask_o),
    .ram_rvalid_i (ram_rvalid_i),
    .ram_rdata_i  (ram_rdata_i)
  );

  // Single-port SRAM with one-cycle read latency and bit-masked writes.
  logic [Width-1:0] mem [Depth];
  always @(posedge clk_i) begin
    ram_rvalid_i <= ram_req_o;
    if (ram_req_o) begin
      if (ram_write_o) mem[ram_addr_o] <= (mem[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
      else             ram_rdata_i     <= mem[ram_addr_o];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [31:0] rd, input logic e);
    check({tag, "_valid"}, 32'(rsp_valid_o), 32'(v));
    check({tag, "_rdata"}, rsp_rdata_o, rd);
    check({tag, "_err"},   32'(rsp_err_o),   32'(e));
  endtask

  task automatic drive(input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    req_valid_i = v;
    req_we_i    = we;
    req_addr_i  = a;
    req_wdata_i = d;
    req_be_i    = be;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int acc;
    int rsp;
    int first;
    int last;

    rst_i       = 1'b1;
    rsp_ready_i = 1'b1;
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    @(negedge clk_i);
    check("rst_req_ready", 32'(req_ready_o), 32'd0);
    check("rst_ram_req",   32'(ram_req_o),   32'd0);
    chk_rsp("rst", 1'b0, 32'h0, 1'b0);
    tick();
    rst_i = 1'b0;
    idle();
    @(negedge clk_i);
    check("post_rst_ready", 32'(req_ready_o), 32'd1);

    // Full-word write then read-back at 0x10
    tick();
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    @(negedge clk_i);
    check("w1_ram_req",   32'(ram_req_o),   32'd1);
    check("w1_ram_write", 32'(ram_write_o), 32'd1);
    check("w1_ram_addr",  32'(ram_addr_o),  32'd4);
    check("w1_wmask",     ram_wmask_o,      32'hFFFFFFFF);
    check("w1_wdata",     ram_wdata_o,      32'hDEADBEEF);
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk_i);
    check("r1_ram_req",   32'(ram_req_o),   32'd1);
    check("r1_ram_write", 32'(ram_write_o), 32'd0);
    check("r1_ram_addr",  32'(ram_addr_o),  32'd4);
    check("r1_ready",     32'(req_ready_o), 32'd1);
    check("w1_no_rsp_yet", 32'(rsp_valid_o), 32'd0);
    tick();
    idle();
    @(negedge clk_i);
    chk_rsp("w1_ack", 1'b1, 32'h0, 1'b0);
    tick();
    @(negedge clk_i);
    chk_rsp("r1_data", 1'b1, 32'hDEADBEEF, 1'b0);
    tick();
    @(negedge clk_i);
    chk_rsp("t1_drain", 1'b0, 32'h0, 1'b0);

    // Partial write with be 0101 over 0xDEADBEEF at 0x20
    tick();
    drive(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF);
    tick();
    drive(1'b1, 1'b1, 32'h20, 32'h55AA1234, 4'b0101);
    @(negedge clk_i);
    check("w2_wmask",    ram_wmask_o,      32'h00FF00FF);
    check("w2_wdata",    ram_wdata_o,      32'h55AA1234);
    check("w2_ram_addr", 32'(ram_addr_o),  32'd8);
    tick();
    drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    @(negedge clk_i);
    check("r2_ready", 32'(req_ready_o), 32'd1);
    chk_rsp("w2a_ack", 1'b1, 32'h0, 1'b0);
    tick();
    idle();
    @(negedge clk_i);
    chk_rsp("w2b_ack", 1'b1, 32'h0, 1'b0);
    tick();
    @(negedge clk_i);
    chk_rsp("r2_data", 1'b1, 32'hDEAABE34, 1'b0);

    // Out-of-range read between two good reads
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    drive(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0);
    @(negedge clk_i);
    check("err_ram_req", 32'(ram_req_o),   32'd0);
    check("err_ready",   32'(req_ready_o), 32'd1);
    tick();
    drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    @(negedge clk_i);
    chk_rsp("err_pre", 1'b1, 32'hDEADBEEF, 1'b0);
    tick();
    idle();
    @(negedge clk_i);
    chk_rsp("err_rsp", 1'b1, 32'h0, 1'b1);
    tick();
    @(negedge clk_i);
    chk_rsp("err_post", 1'b1, 32'hDEAABE34, 1'b0);
    tick();
    @(negedge clk_i);
    chk_rsp("err_drain", 1'b0, 32'h0, 1'b0);

    // Back-pressure: two credits, third request waits for the first pop
    tick();
    rsp_ready_i = 1'b0;
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk_i);
    check("bp_r1_ready", 32'(req_ready_o), 32'd1);
    tick();
    drive(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    @(negedge clk_i);
    check("bp_r2_ready", 32'(req_ready_o), 32'd1);
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk_i);
    check("bp_r3_blocked",  32'(req_ready_o), 32'd0);
    check("bp_r3_no_ram",   32'(ram_req_o),   32'd0);
    chk_rsp("bp_head", 1'b1, 32'hDEADBEEF, 1'b0);
    tick();
    @(negedge clk_i);
    check("bp_full_blocked", 32'(req_ready_o), 32'd0);
    tick();
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_pop_ready",  32'(req_ready_o), 32'd1);
    check("bp_r3_ram_req", 32'(ram_req_o),   32'd1);
    chk_rsp("bp_rsp1", 1'b1, 32'hDEADBEEF, 1'b0);
    tick();
    idle();
    @(negedge clk_i);
    chk_rsp("bp_rsp2", 1'b1, 32'hDEAABE34, 1'b0);
    tick();
    @(negedge clk_i);
    chk_rsp("bp_rsp3", 1'b1, 32'hDEADBEEF, 1'b0);
    tick();
    @(negedge clk_i);
    chk_rsp("bp_drain", 1'b0, 32'h0, 1'b0);

    // Streaming reads, one per cycle, alternating 0x10 / 0x20
    acc   = 0;
    rsp   = 0;
    first = -1;
    last  = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (c < 16) drive(1'b1, 1'b0, ((c % 2) != 0) ? 32'h20 : 32'h10, 32'h0, 4'h0);
      else        idle();
      @(negedge clk_i);
      if (req_valid_i && req_ready_o) acc++;
      if (rsp_valid_o) begin
        check("stream_data", rsp_rdata_o, ((rsp % 2) != 0) ? 32'hDEAABE34 : 32'hDEADBEEF);
        if (first < 0) first = c;
        last = c;
        rsp++;
      end
    end
    check("stream_accepts",   32'(acc),          32'd16);
    check("stream_responses", 32'(rsp),          32'd16);
    check("stream_first",     32'(first),        32'd2);
    check("stream_no_bubble", 32'(last - first), 32'd15);

    // Reset the cycle after a read accept discards it
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    @(negedge clk_i);
    check("rr_accept", 32'(req_ready_o), 32'd1);
    tick();
    idle();
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rr_in_rst_ready", 32'(req_ready_o), 32'd0);
    check("rr_in_rst_valid", 32'(rsp_valid_o), 32'd0);
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rr_after_ready", 32'(req_ready_o), 32'd1);
    check("rr_after_valid", 32'(rsp_valid_o), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      @(negedge clk_i);
      check("rr_no_rsp", 32'(rsp_valid_o), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
